burst_counter_source: RTL and testbench

Bus-configurable test-data source that sits directly upstream of the round-robin arbiter feeding the SRAM FIFO. It replaces the free-running counter input with a controlled one. On START it emits a programmed number of 32-bit words, or runs continuously. Each word has the byte pattern {4n+3, 4n+2, 4n+1, 4n} (mod 256), so the host can check SRAM FIFO fill, wrap and throughput.

---
 rtl/burst_counter_source_pkg.sv | 38 +++
 rtl/burst_counter_source_core.sv | 138 +++++++++++++
 rtl/burst_counter_source.sv | 139 +++++++++++++
 tb/tb_burst_counter_source.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_counter_source_pkg.sv
// Shared definitions for burst_counter_source: register offsets, version, FSM states, word pattern.
// Optional GAP register/WAIT_GAP state is enabled with BURST_COUNTER_SOURCE_GAP_EN.
package burst_counter_source_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OFF_W  = 4;

    localparam logic [OFF_W-1:0] REG_RESET = 4'd0;
    localparam logic [OFF_W-1:0] REG_START = 4'd1;
    localparam logic [OFF_W-1:0] REG_CONF  = 4'd2;
    localparam logic [OFF_W-1:0] REG_WC0   = 4'd3;
    localparam logic [OFF_W-1:0] REG_WC1   = 4'd4;
    localparam logic [OFF_W-1:0] REG_WC2   = 4'd5;
    localparam logic [OFF_W-1:0] REG_WC3   = 4'd6;
    localparam logic [OFF_W-1:0] REG_GAP   = 4'd7;
    localparam logic [OFF_W-1:0] REG_SENT0 = 4'd8;
    localparam logic [OFF_W-1:0] REG_SENT1 = 4'd9;
    localparam logic [OFF_W-1:0] REG_SENT2 = 4'd10;
    localparam logic [OFF_W-1:0] REG_SENT3 = 4'd11;

    localparam logic [BYTE_W-1:0] VERSION = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_WAIT_GAP,
        ST_DONE
    } state_t;

    // Word n carries bytes {4n+3, 4n+2, 4n+1, 4n} mod 256; only n[5:0] matters.
    function automatic logic [DATA_W-1:0] pattern(input logic [5:0] n_lo);
        logic [BYTE_W-1:0] b;
        b = {n_lo, 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

endpackage

// File: rtl/burst_counter_source_core.sv
// Burst FSM, word/sent counters and FIFO handshake; plain register interface, no bus logic.
// Gap insertion between words exists only with BURST_COUNTER_SOURCE_GAP_EN.
module burst_counter_source_core
    import burst_counter_source_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [DATA_W-1:0] word_count,
`ifdef BURST_COUNTER_SOURCE_GAP_EN
    input  logic [BYTE_W-1:0] gap,
`endif
    input  logic              grant,
    output logic              write_req,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sent
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] sent_q, sent_d;
    logic              cont_run_q, cont_run_d;
    logic              write_req_q, write_req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_c;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
    logic [BYTE_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    // A run started continuous ends once CONTINUOUS drops; otherwise it ends at WORD_COUNT.
    assign last_c = cont_run_q ? !continuous : (word_count <= sent_q + 32'd1);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        sent_d     = sent_q;
        cont_run_d = cont_run_q;
        data_d     = data_q;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        if (soft_rst) begin
            state_d    = ST_IDLE;
            n_d        = '0;
            sent_d     = '0;
            cont_run_d = 1'b0;
            data_d     = '0;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            gap_cnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        n_d        = '0;
                        sent_d     = '0;
                        cont_run_d = continuous;
                        data_d     = pattern(6'd0);
`ifdef BURST_COUNTER_SOURCE_GAP_EN
                        gap_cnt_d  = '0;
`endif
                        state_d    = (word_count == '0 && !continuous) ? ST_DONE : ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (grant) begin
                        n_d    = n_q + 32'd1;
                        sent_d = sent_q + 32'd1;
                        data_d = pattern(n_d[5:0]);
                        if (last_c) begin
                            state_d = ST_DONE;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
                        end else if (gap != '0) begin
                            state_d   = ST_WAIT_GAP;
                            gap_cnt_d = gap;
`endif
                        end
                    end
                end
                ST_WAIT_GAP: begin
`ifdef BURST_COUNTER_SOURCE_GAP_EN
                    gap_cnt_d = gap_cnt_q - 8'd1;
                    if (gap_cnt_q <= 8'd1) begin
                        state_d = ST_PRESENT;
                    end
`else
                    state_d = ST_PRESENT;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
        write_req_d = (state_d == ST_PRESENT);
        busy_d      = (state_d == ST_PRESENT) || (state_d == ST_WAIT_GAP);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            sent_q      <= '0;
            cont_run_q  <= 1'b0;
            write_req_q <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            sent_q      <= sent_d;
            cont_run_q  <= cont_run_d;
            write_req_q <= write_req_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign write_req = write_req_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent      = sent_q;

endmodule

// File: rtl/burst_counter_source.sv
// Bus-configurable test-data source: address decode, register file and burst core.
// Define BURST_COUNTER_SOURCE_GAP_EN to add the GAP register at offset 7.
module burst_counter_source
    import burst_counter_source_pkg::*;
#(
    parameter int unsigned BASEADDR  = 16'h0000,
    parameter int unsigned HIGHADDR  = 16'h000f,
    parameter int unsigned ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_B,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic                 FIFO_WRITE_REQ,
    input  logic                 FIFO_READ_GRANT,
    output logic [31:0]          FIFO_DATA,
    output logic                 BUSY
);

    logic [ABUSWIDTH-1:0] off_full_c;
    logic [OFF_W-1:0]     off_c;
    logic                 hit_c, wr_c, rd_c, soft_rst_c, start_c;
    logic [BYTE_W-1:0]    wdata_c, rd_mux_c;
    logic                 busy_c, done_c;
    logic [DATA_W-1:0]    sent_c;

    logic                 conf_q, conf_d;
    logic [DATA_W-1:0]    wc_q, wc_d;
    logic [DATA_W-1:0]    shadow_q, shadow_d;
    logic [BYTE_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_oe_q, rd_oe_d;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
    logic [BYTE_W-1:0]    gap_q, gap_d;
`endif

    // Offset relative to BASEADDR; addresses below BASEADDR wrap high and miss.
    assign off_full_c = BUS_ADD - ABUSWIDTH'(BASEADDR);
    assign hit_c      = off_full_c <= ABUSWIDTH'(HIGHADDR - BASEADDR);
    assign off_c      = off_full_c[OFF_W-1:0];
    assign wr_c       = BUS_WR && hit_c;
    assign rd_c       = BUS_RD && hit_c;
    assign soft_rst_c = wr_c && (off_c == REG_RESET);
    assign start_c    = wr_c && (off_c == REG_START);
    assign wdata_c    = BUS_DATA;

    always_comb begin
        conf_d   = conf_q;
        wc_d     = wc_q;
        shadow_d = shadow_q;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
        gap_d    = gap_q;
`endif
        if (wr_c) begin
            case (off_c)
                REG_CONF: conf_d        = wdata_c[0];
                REG_WC0:  wc_d[7:0]     = wdata_c;
                REG_WC1:  wc_d[15:8]    = wdata_c;
                REG_WC2:  wc_d[23:16]   = wdata_c;
                REG_WC3:  wc_d[31:24]   = wdata_c;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
                REG_GAP:  gap_d         = wdata_c;
`endif
                default: ;
            endcase
        end
        if (soft_rst_c) begin
            shadow_d = '0;
        end else if (rd_c && off_c == REG_SENT0) begin
            shadow_d = sent_c;
        end

        case (off_c)
            REG_RESET: rd_mux_c = VERSION;
            REG_START: rd_mux_c = {6'b0, busy_c, done_c};
            REG_CONF:  rd_mux_c = {7'b0, conf_q};
            REG_WC0:   rd_mux_c = wc_q[7:0];
            REG_WC1:   rd_mux_c = wc_q[15:8];
            REG_WC2:   rd_mux_c = wc_q[23:16];
            REG_WC3:   rd_mux_c = wc_q[31:24];
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            REG_GAP:   rd_mux_c = gap_q;
`endif
            REG_SENT0: rd_mux_c = sent_c[7:0];
            REG_SENT1: rd_mux_c = shadow_q[15:8];
            REG_SENT2: rd_mux_c = shadow_q[23:16];
            REG_SENT3: rd_mux_c = shadow_q[31:24];
            default:   rd_mux_c = '0;
        endcase
        rd_oe_d   = rd_c;
        rd_data_d = rd_c ? rd_mux_c : rd_data_q;
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            conf_q    <= 1'b0;
            wc_q      <= '0;
            shadow_q  <= '0;
            rd_data_q <= '0;
            rd_oe_q   <= 1'b0;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            conf_q    <= conf_d;
            wc_q      <= wc_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= rd_oe_d;
`ifdef BURST_COUNTER_SOURCE_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hzz;

    burst_counter_source_core u_core (
        .clk        (BUS_CLK),
        .rst_n      (BUS_RST_B),
        .soft_rst   (soft_rst_c),
        .start      (start_c),
        .continuous (conf_q),
        .word_count (wc_q),
`ifdef BURST_COUNTER_SOURCE_GAP_EN
        .gap        (gap_q),
`endif
        .grant      (FIFO_READ_GRANT),
        .write_req  (FIFO_WRITE_REQ),
        .data       (FIFO_DATA),
        .busy       (busy_c),
        .done       (done_c),
        .sent       (sent_c)
    );

    assign BUSY = busy_c;

endmodule

// File: tb/tb_burst_counter_source.sv
// Directed bench for burst_counter_source: register table plus hand-written burst sequences.
module tb_burst_counter_source;

`ifdef BURST_COUNTER_SOURCE_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_add;
    logic        bus_rd, bus_wr, grant;
    logic        tb_oe;
    logic [7:0]  tb_dout;
    wire  [7:0]  bus_data;
    wire         req;
    wire  [31:0] fdata;
    wire         busy;

    int checks = 0;
    int errors = 0;

    assign bus_data = tb_oe ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    burst_counter_source #(
        .BASEADDR (16'h0000),
        .HIGHADDR (16'h000f),
        .ABUSWIDTH(16)
    ) dut (
        .BUS_CLK        (clk),
        .BUS_RST_B      (rst_n),
        .BUS_ADD        (bus_add),
        .BUS_DATA       (bus_data),
        .BUS_RD         (bus_rd),
        .BUS_WR         (bus_wr),
        .FIFO_WRITE_REQ (req),
        .FIFO_READ_GRANT(grant),
        .FIFO_DATA      (fdata),
        .BUSY           (busy)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        bus_add = addr;
        tb_dout = data;
        tb_oe   = 1'b1;
        bus_wr  = 1'b1;
        tick();
        bus_wr  = 1'b0;
        tb_oe   = 1'b0;
    endtask

    // Two cycles: strobe, then capture; the trailing cycle lets the DUT release the bus.
    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        bus_add = addr;
        bus_rd  = 1'b1;
        tick();
        bus_rd  = 1'b0;
        data    = bus_data;
        tick();
    endtask

    task automatic read_sent(output logic [31:0] v);
        logic [7:0] b;
        bus_read(16'd8,  b); v[7:0]   = b;
        bus_read(16'd9,  b); v[15:8]  = b;
        bus_read(16'd10, b); v[23:16] = b;
        bus_read(16'd11, b); v[31:24] = b;
    endtask

    task automatic set_wc(input logic [31:0] v);
        bus_write(16'd3, v[7:0]);
        bus_write(16'd4, v[15:8]);
        bus_write(16'd5, v[23:16]);
        bus_write(16'd6, v[31:24]);
    endtask

    function automatic logic [31:0] exp_word(input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4 * i);
        b1 = 8'(4 * i + 1);
        b2 = 8'(4 * i + 2);
        b3 = 8'(4 * i + 3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[16];
        logic [7:0]  rb;
        logic [31:0] sv;
        logic [31:0] words[2];
        int          nw, lows, cnt;

        rst_n = 1'b0; bus_add = '0; bus_rd = 0; bus_wr = 0; grant = 0;
        tb_oe = 0; tb_dout = '0;

        vt[0]  = '{1'b0, 16'd0,  8'h00, 8'h01};
        vt[1]  = '{1'b0, 16'd1,  8'h00, 8'h00};
        vt[2]  = '{1'b0, 16'd2,  8'h00, 8'h00};
        vt[3]  = '{1'b1, 16'd2,  8'hFF, 8'h00};
        vt[4]  = '{1'b0, 16'd2,  8'h00, 8'h01};
        vt[5]  = '{1'b1, 16'd3,  8'h78, 8'h00};
        vt[6]  = '{1'b1, 16'd4,  8'h56, 8'h00};
        vt[7]  = '{1'b1, 16'd5,  8'h34, 8'h00};
        vt[8]  = '{1'b1, 16'd6,  8'h12, 8'h00};
        vt[9]  = '{1'b0, 16'd3,  8'h00, 8'h78};
        vt[10] = '{1'b0, 16'd6,  8'h00, 8'h12};
        vt[11] = '{1'b1, 16'd7,  8'h05, 8'h00};
        vt[12] = '{1'b0, 16'd7,  8'h00, (GAP_EN != 0) ? 8'h05 : 8'h00};
        vt[13] = '{1'b0, 16'd8,  8'h00, 8'h00};
        vt[14] = '{1'b1, 16'd2,  8'h00, 8'h00};
        vt[15] = '{1'b1, 16'd7,  8'h00, 8'h00};

        #3;
        check("reset_req",  32'(req),  32'd0);
        check("reset_data", fdata,     32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) begin
                bus_write(vt[i].addr, vt[i].wdata);
            end else begin
                bus_read(vt[i].addr, rb);
                check($sformatf("reg_vec%0d", i), 32'(rb), 32'(vt[i].exp));
            end
        end

        // Three-word burst, grant every cycle
        set_wc(32'd3);
        grant = 1'b1;
        bus_write(16'd1, 8'h00);
        check("t1_req0",  32'(req), 32'd1);
        check("t1_word0", fdata, 32'h03020100);
        tick();
        check("t1_word1", fdata, 32'h07060504);
        check("t1_req1",  32'(req), 32'd1);
        tick();
        check("t1_word2", fdata, 32'h0B0A0908);
        tick();
        check("t1_req_end",  32'(req),  32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        grant = 1'b0;
        bus_read(16'd1, rb);
        check("t1_status", 32'(rb), 32'h01);
        read_sent(sv);
        check("t1_sent", sv, 32'd3);

        // Gap between words with grant held
        set_wc(32'd2);
        bus_write(16'd7, 8'd2);
        grant = 1'b1;
        bus_write(16'd1, 8'h00);
        nw = 0; lows = 0;
        words[0] = '0; words[1] = '0;
        for (int c = 0; c < 12; c++) begin
            if (req) begin
                if (nw < 2) words[nw] = fdata;
                nw++;
            end else if (nw == 1) begin
                lows++;
            end
            tick();
        end
        grant = 1'b0;
        check("t2_words",  32'(nw),   32'd2);
        check("t2_gaplen", 32'(lows), (GAP_EN != 0) ? 32'd2 : 32'd0);
        check("t2_word0",  words[0], 32'h03020100);
        check("t2_word1",  words[1], 32'h07060504);
        bus_write(16'd7, 8'd0);

        // Zero-length burst goes straight to DONE
        set_wc(32'd0);
        bus_write(16'd1, 8'h00);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (req) cnt++;
            tick();
        end
        check("t3_no_req", 32'(cnt), 32'd0);
        bus_read(16'd1, rb);
        check("t3_status", 32'(rb), 32'h01);

        // Continuous run, pattern wrap, then stop
        bus_write(16'd2, 8'h01);
        grant = 1'b1;
        bus_write(16'd1, 8'h00);
        for (int i = 0; i < 300; i++) begin
            check($sformatf("t4_req%0d", i), 32'(req), 32'd1);
            check($sformatf("t4_word%0d", i), fdata, exp_word(i));
            tick();
        end
        grant = 1'b0;
        bus_write(16'd2, 8'h00);
        grant = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (req) cnt++;
            tick();
        end
        grant = 1'b0;
        check("t4_extra_words", 32'(cnt), 32'd1);
        read_sent(sv);
        check("t4_sent", sv, 32'd301);

        // Soft reset coinciding with a grant
        set_wc(32'd10);
        bus_write(16'd1, 8'h00);
        grant = 1'b1;
        tick(); tick(); tick();
        bus_write(16'd0, 8'h00);
        check("t5_req_after_srst", 32'(req), 32'd0);
        grant = 1'b0;
        read_sent(sv);
        check("t5_sent", sv, 32'd0);
        bus_read(16'd3, rb);
        check("t5_wc_kept", 32'(rb), 32'h0A);
        bus_write(16'd1, 8'h00);
        check("t5_restart_word", fdata, 32'h03020100);
        check("t5_restart_req",  32'(req), 32'd1);
        bus_write(16'd0, 8'h00);

        // START while busy ignored; WORD_COUNT shrunk below sent ends on next grant
        bus_write(16'd1, 8'h00);
        grant = 1'b1;
        tick(); tick(); tick(); tick();
        grant = 1'b0;
        check("t7_word4", fdata, 32'h13121110);
        bus_write(16'd1, 8'h00);
        check("t7_start_ignored", fdata, 32'h13121110);
        check("t7_busy", 32'(busy), 32'd1);
        bus_write(16'd3, 8'd2);
        grant = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (req) cnt++;
            tick();
        end
        grant = 1'b0;
        check("t7_last_words", 32'(cnt), 32'd1);
        read_sent(sv);
        check("t7_sent", sv, 32'd5);

        // Asynchronous reset mid-burst, then grant while idle
        set_wc(32'd10);
        bus_write(16'd1, 8'h00);
        check("t6_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req",  32'(req),  32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_data", fdata,     32'd0);
        tick();
        rst_n = 1'b1;
        grant = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t6_idle_req%0d", c),  32'(req),  32'd0);
            check($sformatf("t6_idle_busy%0d", c), 32'(busy), 32'd0);
            check($sformatf("t6_idle_data%0d", c), fdata,     32'd0);
        end
        grant = 1'b0;
        bus_read(16'd1, rb);
        check("t6_status", 32'(rb), 32'h00);
        read_sent(sv);
        check("t6_sent", sv, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
